// File: rtl/pipeline_pkg.sv
// Shared pipeline types for the IF, fetch_buffer and ID stages.
// Contents: INSTR_W, NOP_INSTR, fetch_entry_t {instr, pc}, NOP_ENTRY.
// No logic; types and constants only.
package pipeline_pkg;

    localparam int INSTR_W = 32;

    // All-zero word is the NOP encoding presented to decode when idle.
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [INSTR_W-1:0] pc;
    } fetch_entry_t;

    localparam fetch_entry_t NOP_ENTRY = '{instr: NOP_INSTR, pc: '0};

endpackage

// File: rtl/fetch_buffer_if.sv
// Fetch-to-decode handshake bundle for fetch_buffer.
// Ports: in_* (fetch side, in_ready back-pressure), flush, out_* (decode side), count.
// slave modport = the buffer; master modport = fetch/decode environment.
interface fetch_buffer_if #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) ();
    localparam int CW = $clog2(DEPTH) + 1;

    logic [DATA_W-1:0] in_instruction;
    logic [DATA_W-1:0] in_pc;
    logic              in_valid;
    logic              in_ready;
    logic              flush;
    logic [DATA_W-1:0] out_instruction;
    logic [DATA_W-1:0] out_pc;
    logic              out_valid;
    logic              out_ready;
    logic [CW-1:0]     count;

    modport slave (
        input  in_instruction, in_pc, in_valid, flush, out_ready,
        output in_ready, out_instruction, out_pc, out_valid, count
    );

    modport master (
        output in_instruction, in_pc, in_valid, flush, out_ready,
        input  in_ready, out_instruction, out_pc, out_valid, count
    );
endinterface

// File: rtl/fetch_buffer_mem.sv
// Entry storage for fetch_buffer: DEPTH x fetch_entry_t registers.
// Ports: i_clk/i_rst, write port (i_we, i_waddr, i_wdata), read port (i_raddr -> o_rdata).
// Synchronous write, combinational read; async reset clears all entries.
module fetch_buffer_mem
    import pipeline_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_we,
    input  logic [AW-1:0] i_waddr,
    input  fetch_entry_t i_wdata,
    input  logic [AW-1:0] i_raddr,
    output fetch_entry_t o_rdata
);

    fetch_entry_t r_mem [DEPTH];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= NOP_ENTRY;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fetch_buffer.sv
// Instruction queue between fetch and decode; flush discards all entries.
// Ports: CLK, RST (async active-high), bus (fetch_buffer_if.slave).
// Optional macro FETCH_BUF_BYPASS_EN: empty-buffer same-cycle bypass to decode.
module fetch_buffer
    import pipeline_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = INSTR_W
) (
    input  logic            CLK,
    input  logic            RST,
    fetch_buffer_if.slave   bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic         w_full;
    logic         w_empty;
    logic         w_bypass;
    logic         w_in_ready;
    logic         w_out_valid;
    logic         w_push;
    logic         w_pop;
    fetch_entry_t w_wdata;
    fetch_entry_t w_rdata;
    fetch_entry_t w_head;

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_wdata = '{instr: bus.in_instruction, pc: bus.in_pc};

`ifdef FETCH_BUF_BYPASS_EN
    // Empty buffer: hand the incoming word straight to decode this cycle.
    assign w_bypass = w_empty && bus.in_valid && !bus.flush && !RST;
`else
    assign w_bypass = 1'b0;
`endif

    // A pop while full does not free a slot for this cycle's push.
    assign w_in_ready  = RST || (!w_full && !bus.flush);
    assign w_out_valid = !RST && ((!w_empty && !bus.flush) || w_bypass);

    // A bypassed word that decode takes is never written.
    assign w_push = bus.in_valid && w_in_ready && !RST && !(w_bypass && bus.out_ready);
    assign w_pop  = w_out_valid && bus.out_ready && !w_bypass;

    always_comb begin
        w_head = NOP_ENTRY;
        if (w_bypass) begin
            w_head = w_wdata;
        end else if (w_out_valid) begin
            w_head = w_rdata;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (bus.flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    fetch_buffer_mem #(.DEPTH(DEPTH)) u_mem (
        .i_clk   (CLK),
        .i_rst   (RST),
        .i_we    (w_push),
        .i_waddr (r_wr_ptr),
        .i_wdata (w_wdata),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rdata)
    );

    assign bus.in_ready        = w_in_ready;
    assign bus.out_valid       = w_out_valid;
    assign bus.out_instruction = w_head.instr;
    assign bus.out_pc          = w_head.pc;
    assign bus.count           = r_count;

endmodule

// File: tb/tb_fetch_buffer.sv
// Scoreboard bench for fetch_buffer: directed scenarios plus random traffic.
// Driver predicts handshakes from a queue model; negedge monitor compares.
// Bypass expectations follow FETCH_BUF_BYPASS_EN when defined.
module tb_fetch_buffer;
    import pipeline_pkg::*;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fetch_buffer_if #(.DATA_W(32), .DEPTH(DEPTH)) bus ();

    fetch_buffer #(.DEPTH(DEPTH), .DATA_W(32)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    fetch_entry_t exp_q[$];
    logic         exp_ir, exp_ov;
    logic [2:0]   exp_cnt;
    logic         mon_en    = 1'b0;
    logic         dead_seen = 1'b0;
    int           n_chk = 0;
    int           n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Apply one cycle of inputs, predict the handshake, then advance past the edge.
    task automatic drive(input logic iv, input logic [31:0] ins, input logic [31:0] pc,
                         input logic ordy, input logic fl);
        int sz;
        bus.in_valid       = iv;
        bus.in_instruction = ins;
        bus.in_pc          = pc;
        bus.out_ready      = ordy;
        bus.flush          = fl;
        sz      = exp_q.size();
        exp_ir  = (sz < DEPTH) && !fl;
        exp_ov  = (sz > 0) && !fl;
`ifdef FETCH_BUF_BYPASS_EN
        if (sz == 0 && iv && !fl) exp_ov = 1'b1;
`endif
        exp_cnt = 3'(sz);
        if (fl) exp_q.delete();
        else if (iv && exp_ir) exp_q.push_back('{instr: ins, pc: pc});
        mon_en = 1'b1;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            chk("in_ready", 64'(bus.in_ready), 64'(exp_ir));
            chk("out_valid", 64'(bus.out_valid), 64'(exp_ov));
            chk("count", 64'(bus.count), 64'(exp_cnt));
            if (bus.out_valid) begin
                if (bus.out_instruction == 32'hDEAD_0000) dead_seen = 1'b1;
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_err++;
                    $display("FAIL head_empty: got instr %0h expected no valid entry", bus.out_instruction);
                end else begin
                    chk("head_instr", 64'(bus.out_instruction), 64'(exp_q[0].instr));
                    chk("head_pc", 64'(bus.out_pc), 64'(exp_q[0].pc));
                    if (bus.out_ready) void'(exp_q.pop_front());
                end
            end else begin
                chk("nop_instr", 64'(bus.out_instruction), 64'(NOP_INSTR));
                chk("nop_pc", 64'(bus.out_pc), 64'h0);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] r;
        bus.in_valid = 1'b0; bus.in_instruction = '0; bus.in_pc = '0;
        bus.out_ready = 1'b0; bus.flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(bus.out_valid), 64'h0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'h1);
        chk("rst_count", 64'(bus.count), 64'h0);
        rst = 1'b0;

        // Mid-stream reset with three entries queued.
        for (int i = 0; i < 3; i++) drive(1'b1, 32'h9000_0000 + 32'(i), 32'h100 + 32'(i), 1'b0, 1'b0);
        chk("pre_rst_count", 64'(bus.count), 64'h3);
        mon_en = 1'b0;
        bus.in_valid = 1'b1;
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", 64'(bus.out_valid), 64'h0);
        chk("midrst_in_ready", 64'(bus.in_ready), 64'h1);
        chk("midrst_out_instr", 64'(bus.out_instruction), 64'h0);
        chk("midrst_out_pc", 64'(bus.out_pc), 64'h0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        chk("postrst_count", 64'(bus.count), 64'h0);

        // Fill, overfill attempt, then drain in order.
        for (int i = 0; i < 4; i++) drive(1'b1, 32'hA000_0001 + 32'(i), 32'(i), 1'b0, 1'b0);
        chk("full_count", 64'(bus.count), 64'h4);
        chk("full_in_ready", 64'(bus.in_ready), 64'h0);
        drive(1'b1, 32'hA000_0005, 32'h4, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        chk("drained_out_valid", 64'(bus.out_valid), 64'h0);
        chk("drained_count", 64'(bus.count), 64'h0);

        // Continuous streaming from empty.
        for (int i = 0; i < 10; i++) drive(1'b1, 32'hB000_0000 + 32'(i), 32'h200 + 32'(4 * i), 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Interleaved 2-push/1-pop so both pointers wrap.
        for (int i = 0; i < 6; i++) drive(1'b1, 32'hC000_0000 + 32'(i), 32'(i), 1'(i % 2), 1'b0);
        for (int i = 0; i < 4; i++) drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Flush with three queued and a word presented in the same cycle.
        for (int i = 0; i < 3; i++) drive(1'b1, 32'hD000_0000 + 32'(i), 32'h300 + 32'(i), 1'b0, 1'b0);
        drive(1'b1, 32'hDEAD_0000, 32'h3F0, 1'b0, 1'b1);
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
        #1;
        chk("flush_count", 64'(bus.count), 64'h0);
        chk("flush_out_valid", 64'(bus.out_valid), 64'h0);
        for (int i = 0; i < 3; i++) drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

`ifdef FETCH_BUF_BYPASS_EN
        drive(1'b1, 32'h1234_5678, 32'h400, 1'b1, 1'b0);
        bus.in_valid = 1'b0;
        #1;
        chk("bypass_count", 64'(bus.count), 64'h0);
`endif

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            r = $urandom;
            drive(($urandom % 4) != 0, {4'h5, r[27:0]}, $urandom, ($urandom % 3) != 0,
                  ($urandom % 20) == 0);
        end
        for (int i = 0; i < 6; i++) drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        chk("end_queue_empty", 64'(exp_q.size()), 64'h0);
        chk("dead_never_seen", 64'(dead_seen), 64'h0);

        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/fetch_buffer.md
Name: fetch_buffer

Overview:
- Small instruction queue between the instruction-fetch stage and decode; decouples fetch from decode stalls.
- Captures each fetched instruction with its PC and presents them in order to decode through a valid/ready handshake.
- Discards all queued entries on a taken-branch flush.
- Drives back-pressure to fetch, which gates the PC write enable.

Parameters:
- DEPTH, 4, number of entries; power of two, minimum 2.
- DATA_W, 32, instruction and PC width.

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  asynchronous, active-high reset.
- in_instruction  input  DATA_W  instruction word from instruction memory.
- in_pc  input  DATA_W  PC of in_instruction.
- in_valid  input  1  fetch presents an instruction this cycle.
- in_ready  output  1  buffer accepts this cycle; fetch holds the PC while low.
- flush  input  1  taken branch/jump; discard all contents.
- out_instruction  output  DATA_W  head instruction to decode.
- out_pc  output  DATA_W  PC of head instruction.
- out_valid  output  1  head entry is valid.
- out_ready  input  1  decode consumes the head this cycle.
- count  output  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset: RST high asynchronously clears wr_ptr, rd_ptr and count to 0, and storage to 0. While RST is high: out_valid=0, in_ready=1, out_instruction=0, out_pc=0. Reset asserted mid-operation drops all entries immediately.
- Push: occurs when in_valid && in_ready. The entry is written at wr_ptr on the rising CLK edge and wr_ptr advances.
- Pop: occurs when out_valid && out_ready. rd_ptr advances on the rising CLK edge.
- in_ready = (count != DEPTH) && !flush.
  - When full, a pop in the same cycle does not open a slot; in_ready stays 0 that cycle.
- out_valid = (count != 0) && !flush.
- out_instruction/out_pc: storage[rd_ptr] when out_valid, otherwise 0, which is the NOP encoding.
- Latency: an entry pushed in cycle N is visible at the head in cycle N+1 at the earliest (no bypass).
- Simultaneous push and pop, non-empty and not full: count unchanged, both pointers advance.
- Pointer wrap: pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. Occupancy is tracked by count, never by pointer comparison.
- Flush: synchronous, takes priority over push and pop.
  - On the edge: count=0 and rd_ptr=wr_ptr=0.
  - in_valid data presented in the flush cycle is dropped.
  - No pop is reported in the flush cycle.
- No state machine beyond the occupancy counter. Illegal conditions (push when full, pop when empty) cannot occur because of the ready/valid gating.

Optional Feature:
- Macro: FETCH_BUF_BYPASS_EN.
- Defined: when count==0, in_valid=1 and flush=0:
  - out_valid=1 combinationally, and out_instruction/out_pc follow in_instruction/in_pc in the same cycle.
  - If out_ready=1 as well, the instruction is consumed without being written; pointers and count are unchanged.
  - If out_ready=0, it is written normally.
- Undefined: no combinational path from the in_* signals to the out_* signals; minimum latency is 1 cycle.

Decomposition:
- Shared package pipeline_pkg holds:
  - INSTR_W=32.
  - NOP_INSTR=32'h0000_0000.
  - Typedef fetch_entry_t {instr, pc}, used by the IF, fetch_buffer and ID stages.
- One sub-module, fetch_buffer_mem: DEPTH x fetch_entry_t register array with synchronous write and combinational read. The top level holds the pointers, count and handshake logic.

Test Plan:
- Reset: assert RST mid-stream with count=3 -> same cycle out_valid=0, in_ready=1, out_instruction=0; after release, count=0.
- Fill then drain: push 0xA0000001..0xA0000004 at PCs 0..3 with out_ready=0 -> count=4 and in_ready=0; a fifth push is ignored. Then out_ready=1 -> pops in order with PCs 0,1,2,3, then out_valid=0.
- Streaming: in_valid=1 and out_ready=1 continuously for 10 cycles from empty -> count stays ≤1 and no instruction is lost or reordered. Without bypass, the first out_valid appears 1 cycle after the first push.
- Wrap-around: push 6 and pop 6, interleaved 2-push/1-pop -> pointers wrap past DEPTH-1 and data at PCs 4,5 is read correctly.
- Flush: count=3 and flush=1 with in_valid=1 (instruction 0xDEAD0000) -> next cycle count=0 and out_valid=0, and 0xDEAD0000 never appears at the output.
- Bypass (FETCH_BUF_BYPASS_EN): empty, in_valid=1, in_instruction=0x12345678, out_ready=1 -> out_valid=1 and out_instruction=0x12345678 in the same cycle, count stays 0.
